// File: rtl/streaming_fifo_v2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : streaming_fifo_v2                                          |
// | Description : First-word-fall-through streaming FIFO between two         |
// |               valid/ready stages. Arbitrary width and depth, with        |
// |               almost-full/almost-empty flags, free-space output and a    |
// |               synchronous flush.                                         |
// |               Optional high-water-mark monitor: STREAMING_FIFO_HWM_EN    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module streaming_fifo_v2 #(
   parameter int WIDTH     = 24,
   parameter int DEPTH     = 512,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] in0_V_V_TDATA,
   input  logic             in0_V_V_TVALID,
   output logic             in0_V_V_TREADY,
   output logic [WIDTH-1:0] out_V_V_TDATA,
   output logic             out_V_V_TVALID,
   input  logic             out_V_V_TREADY,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    free,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    max_count
);

   // Pointer width; depth need not be a power of two, so wrap is explicit.
   localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);
   localparam logic [CW-1:0]      c_depth = CW'(DEPTH);
   localparam logic [CW-1:0]      c_af    = CW'(AF_THRESH);
   localparam logic [CW-1:0]      c_ae    = CW'(AE_THRESH);

   logic [WIDTH-1:0]   r_mem [0:DEPTH-1];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic [CW-1:0]      w_count_next;
   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_wr_fire;
   logic               w_rd_fire;

   function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
      return (p == c_last) ? '0 : p + c_ptr_w'(1);
   endfunction

   // Ready/valid depend only on occupancy and flush, never on the far side's handshake.
   assign w_in_ready  = (r_count != c_depth) && !flush;
   assign w_out_valid = (r_count != '0) && !flush;
   assign w_wr_fire   = in0_V_V_TVALID && w_in_ready && !ap_rst;
   assign w_rd_fire   = w_out_valid && out_V_V_TREADY && !ap_rst;

   assign in0_V_V_TREADY = w_in_ready;
   assign out_V_V_TVALID = w_out_valid;
   assign out_V_V_TDATA  = r_mem[r_rd_ptr];

   assign count        = r_count;
   assign free         = c_depth - r_count;
   assign almost_full  = (r_count >= c_af);
   assign almost_empty = (r_count <= c_ae);

   // Next occupancy: reset/flush empty the FIFO, otherwise +1/-1/hold by handshake.
   always_comb begin
      w_count_next = r_count;
      if (ap_rst || flush) begin
         w_count_next = '0;
      end else if (w_wr_fire && !w_rd_fire) begin
         w_count_next = r_count + CW'(1);
      end else if (!w_wr_fire && w_rd_fire) begin
         w_count_next = r_count - CW'(1);
      end
   end

   // Storage array; contents survive reset and flush.
   always_ff @(posedge ap_clk) begin
      if (w_wr_fire) begin
         r_mem[r_wr_ptr] <= in0_V_V_TDATA;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge ap_clk) begin
      if (ap_rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_fire) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         if (w_rd_fire) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      r_count <= w_count_next;
   end

`ifdef STREAMING_FIFO_HWM_EN
   logic [CW-1:0] r_max_count;

   // High-water mark tracks peak occupancy; only reset clears it, flush does not.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_max_count <= '0;
      end else if (w_count_next > r_max_count) begin
         r_max_count <= w_count_next;
      end
   end

   assign max_count = r_max_count;
`else
   assign max_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_streaming_fifo_v2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_streaming_fifo_v2                                       |
// | Description : Self-checking bench for streaming_fifo_v2: directed vector |
// |               table and streaming sequence on a DEPTH=5 instance, random |
// |               traffic against a queue model on a DEPTH=7 instance.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_streaming_fifo_v2;

   localparam int W   = 24;
   localparam int D5  = 5;
   localparam int D7  = 7;
   localparam int CW5 = $clog2(D5 + 1);
   localparam int CW7 = $clog2(D7 + 1);
`ifdef STREAMING_FIFO_HWM_EN
   localparam bit HWM = 1'b1;
`else
   localparam bit HWM = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DEPTH=5 instance (directed), defaults AF=3, AE=2
   logic           a_rst = 1'b1, a_fl = 1'b0, a_iv = 1'b0, a_or = 1'b0;
   logic [W-1:0]   a_id = '0;
   logic           a_ir, a_ov, a_af, a_ae;
   logic [W-1:0]   a_od;
   logic [CW5-1:0] a_cnt, a_free, a_max;

   // DEPTH=7 instance (random), defaults AF=5, AE=2
   logic           b_rst = 1'b1, b_fl = 1'b0, b_iv = 1'b0, b_or = 1'b0;
   logic [W-1:0]   b_id = '0;
   logic           b_ir, b_ov, b_af, b_ae;
   logic [W-1:0]   b_od;
   logic [CW7-1:0] b_cnt, b_free, b_max;

   streaming_fifo_v2 #(.WIDTH(W), .DEPTH(D5)) u_a (
      .ap_clk(clk), .ap_rst(a_rst), .flush(a_fl),
      .in0_V_V_TDATA(a_id), .in0_V_V_TVALID(a_iv), .in0_V_V_TREADY(a_ir),
      .out_V_V_TDATA(a_od), .out_V_V_TVALID(a_ov), .out_V_V_TREADY(a_or),
      .count(a_cnt), .free(a_free), .almost_full(a_af), .almost_empty(a_ae),
      .max_count(a_max)
   );

   streaming_fifo_v2 #(.WIDTH(W), .DEPTH(D7)) u_b (
      .ap_clk(clk), .ap_rst(b_rst), .flush(b_fl),
      .in0_V_V_TDATA(b_id), .in0_V_V_TVALID(b_iv), .in0_V_V_TREADY(b_ir),
      .out_V_V_TDATA(b_od), .out_V_V_TVALID(b_ov), .out_V_V_TREADY(b_or),
      .count(b_cnt), .free(b_free), .almost_full(b_af), .almost_empty(b_ae),
      .max_count(b_max)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic         rst;
      logic         fl;
      logic         v;
      logic [W-1:0] d;
      logic         r;
      logic         chk;
      int           cnt;
      logic [W-1:0] ed;
      logic         edchk;
      int           emax;
   } vec_t;

   vec_t tbl[$];

   // Expected flags are derived from the expected occupancy and flush input.
   task automatic check_a(input string tag, input int ecnt, input logic fl,
                          input logic [W-1:0] ed, input logic edchk, input int emax);
      chk({tag, " count"},        32'(a_cnt), 32'(ecnt));
      chk({tag, " free"},         32'(a_free), 32'(D5 - ecnt));
      chk({tag, " in_ready"},     32'(a_ir), 32'((ecnt != D5) && !fl));
      chk({tag, " out_valid"},    32'(a_ov), 32'((ecnt != 0) && !fl));
      chk({tag, " almost_full"},  32'(a_af), 32'(ecnt >= D5 - 2));
      chk({tag, " almost_empty"}, 32'(a_ae), 32'(ecnt <= 2));
      chk({tag, " max_count"},    32'(a_max), HWM ? 32'(emax) : 32'd0);
      if (edchk) chk({tag, " data"}, 32'(a_od), 32'(ed));
   endtask

   logic [W-1:0] q[$];
   int           mx;
   logic         fl;
   logic         wr, rd;

   initial begin
      //          rst   fl    v     d            r     chk   cnt ed           edchk emax
      // Fill to full with ready low, offer a 6th word, then drain.
      tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,       1'b0, 1'b0, 0, 24'h0,       1'b0, 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000001,  1'b0, 1'b1, 0, 24'h0,       1'b0, 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000002,  1'b0, 1'b1, 1, 24'h000001,  1'b1, 1});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000003,  1'b0, 1'b1, 2, 24'h000001,  1'b1, 2});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000004,  1'b0, 1'b1, 3, 24'h000001,  1'b1, 3});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000005,  1'b0, 1'b1, 4, 24'h000001,  1'b1, 4});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000006,  1'b0, 1'b1, 5, 24'h000001,  1'b1, 5});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,       1'b1, 1'b1, 5, 24'h000001,  1'b1, 5});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,       1'b1, 1'b1, 4, 24'h000002,  1'b1, 5});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,       1'b1, 1'b1, 3, 24'h000003,  1'b1, 5});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,       1'b1, 1'b1, 2, 24'h000004,  1'b1, 5});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,       1'b1, 1'b1, 1, 24'h000005,  1'b1, 5});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,       1'b0, 1'b1, 0, 24'h0,       1'b0, 5});
      // Reset, peak fill 4, flush with valid/ready high, write 0xABCDEF, peak fill 2, reset.
      tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,       1'b0, 1'b0, 0, 24'h0,       1'b0, 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000A01,  1'b0, 1'b1, 0, 24'h0,       1'b0, 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000A02,  1'b0, 1'b1, 1, 24'h000A01,  1'b1, 1});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000A03,  1'b0, 1'b1, 2, 24'h000A01,  1'b1, 2});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000A04,  1'b0, 1'b1, 3, 24'h000A01,  1'b1, 3});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 24'h111111,  1'b1, 1'b1, 4, 24'h0,       1'b0, 4});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'hABCDEF,  1'b0, 1'b1, 0, 24'h0,       1'b0, 4});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000B02,  1'b0, 1'b1, 1, 24'hABCDEF,  1'b1, 4});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,       1'b1, 1'b1, 2, 24'hABCDEF,  1'b1, 4});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,       1'b1, 1'b1, 1, 24'h000B02,  1'b1, 4});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,       1'b0, 1'b1, 0, 24'h0,       1'b0, 4});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,       1'b0, 1'b0, 0, 24'h0,       1'b0, 0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,       1'b0, 1'b1, 0, 24'h0,       1'b0, 0});

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         a_rst = tbl[i].rst;
         a_fl  = tbl[i].fl;
         a_iv  = tbl[i].v;
         a_id  = tbl[i].d;
         a_or  = tbl[i].r;
         @(negedge clk);
         if (tbl[i].chk)
            check_a($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].fl, tbl[i].ed,
                    tbl[i].edchk, tbl[i].emax);
      end

      // Preload three words, then stream 20 beats in and out at occupancy 3.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         a_iv = 1'b1; a_id = 24'(16 + i); a_or = 1'b0;
      end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         a_iv = 1'b1; a_id = 24'(19 + i); a_or = 1'b1;
         @(negedge clk);
         chk($sformatf("stream%0d count", i), 32'(a_cnt), 32'd3);
         chk($sformatf("stream%0d data", i),  32'(a_od),  32'(16 + i));
      end
      @(posedge clk); #1;
      a_iv = 1'b0; a_or = 1'b0;

      // Random traffic on the DEPTH=7 instance against a queue model.
      @(posedge clk); #1;
      b_rst = 1'b0;
      mx = 0;
      for (int n = 0; n < 10000; n++) begin
         fl   = ($urandom_range(63) == 0);
         b_fl = fl;
         b_iv = 1'($urandom_range(1));
         b_id = 24'($urandom);
         b_or = 1'($urandom_range(1));
         @(negedge clk);
         chk("rnd count",        32'(b_cnt), 32'(q.size()));
         chk("rnd free",         32'(b_free), 32'(D7 - q.size()));
         chk("rnd in_ready",     32'(b_ir), 32'((q.size() != D7) && !fl));
         chk("rnd out_valid",    32'(b_ov), 32'((q.size() != 0) && !fl));
         chk("rnd almost_full",  32'(b_af), 32'(q.size() >= D7 - 2));
         chk("rnd almost_empty", 32'(b_ae), 32'(q.size() <= 2));
         chk("rnd max_count",    32'(b_max), HWM ? 32'(mx) : 32'd0);
         if (q.size() != 0) chk("rnd data", 32'(b_od), 32'(q[0]));
         wr = b_iv && (q.size() != D7) && !fl;
         rd = b_or && (q.size() != 0) && !fl;
         if (fl) begin
            q.delete();
         end else begin
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(b_id);
         end
         if (q.size() > mx) mx = q.size();
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
